// File: rtl/core101_ctrl_pkg.sv
// Shared Core101 control constants: state codes, opcodes, datapath select encodings.
// Used by both the control unit and the datapath so the encodings cannot drift apart.
package core101_ctrl_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_EXECUTE   = 4'd3,
        ST_MEMORY    = 4'd4,
        ST_WRITEBACK = 4'd5,
        ST_TRAP      = 4'd15
    } state_t;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [1:0] SRC_A_PC     = 2'd0;
    localparam logic [1:0] SRC_A_OLD_PC = 2'd1;
    localparam logic [1:0] SRC_A_RS1    = 2'd2;

    localparam logic [1:0] SRC_B_RS2    = 2'd0;
    localparam logic [1:0] SRC_B_IMM    = 2'd1;
    localparam logic [1:0] SRC_B_FOUR   = 2'd2;

    localparam logic [1:0] ALU_ADD      = 2'd0;
    localparam logic [1:0] ALU_FUNCT    = 2'd1;
    localparam logic [1:0] ALU_BRANCH   = 2'd2;

    localparam logic [1:0] WB_ALU       = 2'd0;
    localparam logic [1:0] WB_MDR       = 2'd1;
    localparam logic [1:0] WB_PC        = 2'd2;
    localparam logic [1:0] WB_IMM       = 2'd3;

    localparam logic PC_SRC_ALU    = 1'b0;
    localparam logic PC_SRC_TARGET = 1'b1;

    // One-hot instruction class bit positions.
    localparam int CLS_W        = 11;
    localparam int CLS_LUI      = 0;
    localparam int CLS_AUIPC    = 1;
    localparam int CLS_JAL      = 2;
    localparam int CLS_JALR     = 3;
    localparam int CLS_BRANCH   = 4;
    localparam int CLS_LOAD     = 5;
    localparam int CLS_STORE    = 6;
    localparam int CLS_OP_IMM   = 7;
    localparam int CLS_OP       = 8;
    localparam int CLS_MISC_MEM = 9;
    localparam int CLS_SYSTEM   = 10;

    typedef logic [CLS_W-1:0] insn_class_t;

endpackage

// File: rtl/ctrl_opcode_decoder.sv
// Combinational opcode classifier: one-hot class vector plus legal flag.
// Every legal opcode ends in 2'b11, so compressed-space encodings fall out as illegal.
module ctrl_opcode_decoder
    import core101_ctrl_pkg::*;
(
    input  logic [6:0]  i_opcode,
    output insn_class_t o_class,
    output logic        o_legal
);

    always_comb begin
        o_class = '0;
        case (i_opcode)
            OPC_LUI:      o_class[CLS_LUI]      = 1'b1;
            OPC_AUIPC:    o_class[CLS_AUIPC]    = 1'b1;
            OPC_JAL:      o_class[CLS_JAL]      = 1'b1;
            OPC_JALR:     o_class[CLS_JALR]     = 1'b1;
            OPC_BRANCH:   o_class[CLS_BRANCH]   = 1'b1;
            OPC_LOAD:     o_class[CLS_LOAD]     = 1'b1;
            OPC_STORE:    o_class[CLS_STORE]    = 1'b1;
            OPC_OP_IMM:   o_class[CLS_OP_IMM]   = 1'b1;
            OPC_OP:       o_class[CLS_OP]       = 1'b1;
            OPC_MISC_MEM: o_class[CLS_MISC_MEM] = 1'b1;
            OPC_SYSTEM:   o_class[CLS_SYSTEM]   = 1'b1;
            default:      o_class = '0;
        endcase
        o_legal = |o_class;
    end

endmodule

// File: rtl/control_unit.sv
// Core101 multi-cycle RV32I control unit: sequences the datapath and owns the memory handshake.
// Build option CORE101_ILLEGAL_TRAP_EN: illegal opcodes lock the FSM in TRAP until reset.
//
// state     | meaning
// IDLE      | post-reset, one cycle, all outputs low
// FETCH     | read at PC; on mem_ready load IR/OLD_PC and PC <= PC+4
// DECODE    | capture opcode; TARGET <= OLD_PC + IMM
// EXECUTE   | class-specific ALU / PC / register update
// MEMORY    | load or store at ALU result, held until mem_ready
// WRITEBACK | register file write from ALU or MDR
// TRAP      | illegal instruction seen, held until reset
module control_unit
    import core101_ctrl_pkg::*;
(
    input  logic               control_unit_clock,
    input  logic               control_unit_reset,
    input  logic [6:0]         opcode,
    input  logic               branch_taken,
    input  logic               mem_ready,
    output logic               mem_read,
    output logic               mem_write,
    output logic               addr_sel,
    output logic               ir_write,
    output logic               mdr_write,
    output logic               pc_write,
    output logic               pc_src,
    output logic               target_write,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic               reg_write,
    output logic [1:0]         wb_sel,
    output logic               illegal_insn,
    output logic [STATE_W-1:0] state
);

    state_t      r_state;
    logic [6:0]  r_opcode;
    logic [6:0]  w_dec_opcode;
    insn_class_t w_class;
    logic        w_legal;

    // In DECODE the live opcode is classified; afterwards the captured copy.
    assign w_dec_opcode = (r_state == ST_DECODE) ? opcode : r_opcode;

    ctrl_opcode_decoder u_dec (
        .i_opcode (w_dec_opcode),
        .o_class  (w_class),
        .o_legal  (w_legal)
    );

    always_ff @(posedge control_unit_clock or posedge control_unit_reset) begin
        if (control_unit_reset) begin
            r_state  <= ST_IDLE;
            r_opcode <= '0;
        end else begin
            case (r_state)
                ST_IDLE: r_state <= ST_FETCH;
                ST_FETCH: begin
                    if (mem_ready)
                        r_state <= ST_DECODE;
                end
                ST_DECODE: begin
                    r_opcode <= opcode;
                    if (w_legal)
                        r_state <= ST_EXECUTE;
                    else
`ifdef CORE101_ILLEGAL_TRAP_EN
                        r_state <= ST_TRAP;
`else
                        r_state <= ST_FETCH;
`endif
                end
                ST_EXECUTE: begin
                    if (w_class[CLS_OP] || w_class[CLS_OP_IMM])
                        r_state <= ST_WRITEBACK;
                    else if (w_class[CLS_LOAD] || w_class[CLS_STORE])
                        r_state <= ST_MEMORY;
                    else
                        r_state <= ST_FETCH;
                end
                ST_MEMORY: begin
                    if (mem_ready)
                        r_state <= w_class[CLS_LOAD] ? ST_WRITEBACK : ST_FETCH;
                end
                ST_WRITEBACK: r_state <= ST_FETCH;
`ifdef CORE101_ILLEGAL_TRAP_EN
                ST_TRAP: r_state <= ST_TRAP;
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign state = r_state;

    always_comb begin
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        addr_sel     = 1'b0;
        ir_write     = 1'b0;
        mdr_write    = 1'b0;
        pc_write     = 1'b0;
        pc_src       = PC_SRC_ALU;
        target_write = 1'b0;
        alu_src_a    = SRC_A_PC;
        alu_src_b    = SRC_B_RS2;
        alu_op       = ALU_ADD;
        reg_write    = 1'b0;
        wb_sel       = WB_ALU;
        illegal_insn = 1'b0;
        case (r_state)
            ST_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    pc_src    = PC_SRC_ALU;
                    alu_src_a = SRC_A_PC;
                    alu_src_b = SRC_B_FOUR;
                    alu_op    = ALU_ADD;
                end
            end
            ST_DECODE: begin
                target_write = 1'b1;
                alu_src_a    = SRC_A_OLD_PC;
                alu_src_b    = SRC_B_IMM;
                alu_op       = ALU_ADD;
            end
            ST_EXECUTE: begin
                if (w_class[CLS_OP]) begin
                    alu_src_a = SRC_A_RS1;
                    alu_src_b = SRC_B_RS2;
                    alu_op    = ALU_FUNCT;
                end else if (w_class[CLS_OP_IMM]) begin
                    alu_src_a = SRC_A_RS1;
                    alu_src_b = SRC_B_IMM;
                    alu_op    = ALU_FUNCT;
                end else if (w_class[CLS_LOAD] || w_class[CLS_STORE]) begin
                    alu_src_a = SRC_A_RS1;
                    alu_src_b = SRC_B_IMM;
                end else if (w_class[CLS_BRANCH]) begin
                    alu_src_a = SRC_A_RS1;
                    alu_src_b = SRC_B_RS2;
                    alu_op    = ALU_BRANCH;
                    pc_write  = branch_taken;
                    pc_src    = PC_SRC_TARGET;
                end else if (w_class[CLS_JAL]) begin
                    reg_write = 1'b1;
                    wb_sel    = WB_PC;
                    pc_write  = 1'b1;
                    pc_src    = PC_SRC_TARGET;
                end else if (w_class[CLS_JALR]) begin
                    // Link value is the already-incremented PC; jump target comes from the ALU.
                    reg_write = 1'b1;
                    wb_sel    = WB_PC;
                    alu_src_a = SRC_A_RS1;
                    alu_src_b = SRC_B_IMM;
                    pc_write  = 1'b1;
                    pc_src    = PC_SRC_ALU;
                end else if (w_class[CLS_LUI]) begin
                    reg_write = 1'b1;
                    wb_sel    = WB_IMM;
                end else if (w_class[CLS_AUIPC]) begin
                    alu_src_a = SRC_A_OLD_PC;
                    alu_src_b = SRC_B_IMM;
                    reg_write = 1'b1;
                    wb_sel    = WB_ALU;
                end
            end
            ST_MEMORY: begin
                addr_sel = 1'b1;
                if (w_class[CLS_LOAD]) begin
                    mem_read  = 1'b1;
                    mdr_write = mem_ready;
                end else begin
                    mem_write = 1'b1;
                end
            end
            ST_WRITEBACK: begin
                reg_write = 1'b1;
                wb_sel    = w_class[CLS_LOAD] ? WB_MDR : WB_ALU;
            end
            ST_TRAP: begin
`ifdef CORE101_ILLEGAL_TRAP_EN
                illegal_insn = 1'b1;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit; expectations follow CORE101_ILLEGAL_TRAP_EN.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic       branch_taken;
    logic       mem_ready;
    logic       mem_read, mem_write, addr_sel, ir_write, mdr_write, pc_write, pc_src;
    logic       target_write, reg_write, illegal_insn;
    logic [1:0] alu_src_a, alu_src_b, alu_op, wb_sel;
    logic [3:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    control_unit dut (
        .control_unit_clock (clk),
        .control_unit_reset (rst),
        .opcode             (opcode),
        .branch_taken       (branch_taken),
        .mem_ready          (mem_ready),
        .mem_read           (mem_read),
        .mem_write          (mem_write),
        .addr_sel           (addr_sel),
        .ir_write           (ir_write),
        .mdr_write          (mdr_write),
        .pc_write           (pc_write),
        .pc_src             (pc_src),
        .target_write       (target_write),
        .alu_src_a          (alu_src_a),
        .alu_src_b          (alu_src_b),
        .alu_op             (alu_op),
        .reg_write          (reg_write),
        .wb_sel             (wb_sel),
        .illegal_insn       (illegal_insn),
        .state              (state)
    );

    always #5 clk = ~clk;

    wire [17:0] all_outs = {mem_read, mem_write, addr_sel, ir_write, mdr_write, pc_write, pc_src,
                            target_write, alu_src_a, alu_src_b, alu_op, reg_write, wb_sel, illegal_insn};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from FETCH (called at posedge+1) until it re-enters FETCH or TRAP.
    task automatic run_insn(input logic [6:0] op, input int fw, input int mw, input logic bt,
                            output int cycles, output int mdr_pulses, output int unstable,
                            output logic ex_pcw, output logic ex_pcs);
        int    fcnt = 0;
        int    mcnt = 0;
        logic  is_load;
        logic [3:0] st;
        bit    done = 0;
        cycles = 0; mdr_pulses = 0; unstable = 0; ex_pcw = 1'b0; ex_pcs = 1'b0;
        is_load = (op == 7'b0000011);
        while (!done) begin
            st           = state;
            opcode       = op;
            branch_taken = bt;
            if (st == 4'd1)      mem_ready = (fcnt >= fw);
            else if (st == 4'd4) mem_ready = (mcnt >= mw);
            else                 mem_ready = 1'($urandom_range(0, 1));
            #1;
            if (mem_read && mem_write) unstable++;
            if (st == 4'd1 && !mem_ready) begin
                fcnt++;
                if (!(mem_read && !addr_sel && !ir_write && !pc_write)) unstable++;
            end
            if (st == 4'd4 && !mem_ready) begin
                mcnt++;
                if (mem_read !== is_load || mem_write !== !is_load || addr_sel !== 1'b1 || mdr_write)
                    unstable++;
            end
            if (mdr_write) mdr_pulses++;
            if (st == 4'd3) begin
                ex_pcw = pc_write;
                ex_pcs = pc_src;
            end
            tick();
            cycles++;
            if ((state == 4'd1 && st != 4'd1) || state == 4'd15) done = 1;
            else if (cycles >= 40) begin
                check_eq("insn_timeout", 32'(cycles), 32'd0);
                done = 1;
            end
        end
    endtask

    typedef struct {
        logic [6:0] op;
        int         fw;
        int         mw;
        logic       bt;
        int         cyc;
        logic       pcw;
        logic       pcs;
        int         mdr;
    } vec_t;

    vec_t vecs[12];

    task automatic do_illegal(input logic [6:0] op);
        int   cyc, mdr, uns;
        logic pcw, pcs;
        run_insn(op, 0, 0, 1'b0, cyc, mdr, uns, pcw, pcs);
        check_eq("illegal_cycles", 32'(cyc), 32'd2);
`ifdef CORE101_ILLEGAL_TRAP_EN
        check_eq("trap_state", 32'(state), 32'd15);
        check_eq("trap_flag", 32'(illegal_insn), 32'd1);
        mem_ready = 1'b1;
        repeat (3) tick();
        check_eq("trap_held_state", 32'(state), 32'd15);
        check_eq("trap_held_outs", 32'(all_outs), 32'h00001);
        rst = 1'b1;
        #1;
        check_eq("trap_reset_state", 32'(state), 32'd0);
        check_eq("trap_reset_flag", 32'(illegal_insn), 32'd0);
        tick();
        rst = 1'b0;
        tick();
`else
        check_eq("illegal_back_to_fetch", 32'(state), 32'd1);
        check_eq("illegal_flag_low", 32'(illegal_insn), 32'd0);
`endif
        check_eq("post_illegal_fetch", 32'(state), 32'd1);
    endtask

    initial begin
        int   cyc, mdr, uns;
        logic pcw, pcs;

        //            op          fw mw bt   cyc pcw   pcs   mdr
        vecs[0]  = '{7'b0000011, 2, 2, 1'b0, 9, 1'b0, 1'b0, 1};  // LW with waits
        vecs[1]  = '{7'b1100011, 0, 0, 1'b1, 3, 1'b1, 1'b1, 0};  // BEQ taken
        vecs[2]  = '{7'b1100011, 0, 0, 1'b0, 3, 1'b0, 1'b1, 0};  // BEQ not taken
        vecs[3]  = '{7'b1101111, 0, 0, 1'b0, 3, 1'b1, 1'b1, 0};  // JAL
        vecs[4]  = '{7'b1100111, 0, 0, 1'b0, 3, 1'b1, 1'b0, 0};  // JALR
        vecs[5]  = '{7'b0110111, 0, 0, 1'b0, 3, 1'b0, 1'b0, 0};  // LUI
        vecs[6]  = '{7'b0010111, 0, 0, 1'b0, 3, 1'b0, 1'b0, 0};  // AUIPC
        vecs[7]  = '{7'b0100011, 1, 3, 1'b0, 8, 1'b0, 1'b0, 0};  // SW with waits
        vecs[8]  = '{7'b0010011, 0, 0, 1'b0, 4, 1'b0, 1'b0, 0};  // ADDI
        vecs[9]  = '{7'b0001111, 0, 0, 1'b0, 3, 1'b0, 1'b0, 0};  // FENCE
        vecs[10] = '{7'b1110011, 0, 0, 1'b0, 3, 1'b0, 1'b0, 0};  // SYSTEM
        vecs[11] = '{7'b0000011, 0, 0, 1'b0, 5, 1'b0, 1'b0, 1};  // LW zero-wait

        rst = 1'b1; opcode = '0; branch_taken = 1'b0; mem_ready = 1'b1;
        repeat (3) tick();
        check_eq("reset_outs", 32'(all_outs), 32'd0);
        check_eq("reset_state", 32'(state), 32'd0);
        rst = 1'b0;
        #1;
        check_eq("idle_outs", 32'(all_outs), 32'd0);
        check_eq("idle_state", 32'(state), 32'd0);

        // ADD walked state by state.
        tick();
        opcode = 7'b0110011; mem_ready = 1'b1;
        #1;
        check_eq("fetch_state", 32'(state), 32'd1);
        check_eq("fetch_outs", 32'(all_outs), 32'b1_0_0_1_0_1_0_0_00_10_00_0_00_0);
        tick(); #1;
        check_eq("decode_state", 32'(state), 32'd2);
        check_eq("decode_outs", 32'(all_outs), 32'b0_0_0_0_0_0_0_1_01_01_00_0_00_0);
        tick(); #1;
        check_eq("exec_add_state", 32'(state), 32'd3);
        check_eq("exec_add_outs", 32'(all_outs), 32'b0_0_0_0_0_0_0_0_10_00_01_0_00_0);
        tick(); #1;
        check_eq("wb_add_state", 32'(state), 32'd5);
        check_eq("wb_add_outs", 32'(all_outs), 32'b0_0_0_0_0_0_0_0_00_00_00_1_00_0);
        tick();
        check_eq("add_return_fetch", 32'(state), 32'd1);

        foreach (vecs[i]) begin
            run_insn(vecs[i].op, vecs[i].fw, vecs[i].mw, vecs[i].bt, cyc, mdr, uns, pcw, pcs);
            check_eq($sformatf("cycles_%0d", i), 32'(cyc), 32'(vecs[i].cyc));
            check_eq($sformatf("mdr_pulses_%0d", i), 32'(mdr), 32'(vecs[i].mdr));
            check_eq($sformatf("handshake_%0d", i), 32'(uns), 32'd0);
            check_eq($sformatf("ex_pc_write_%0d", i), 32'(pcw), 32'(vecs[i].pcw));
            if (vecs[i].pcw) check_eq($sformatf("ex_pc_src_%0d", i), 32'(pcs), 32'(vecs[i].pcs));
            check_eq($sformatf("back_in_fetch_%0d", i), 32'(state), 32'd1);
        end

        // Reset in MEMORY during a store.
        opcode = 7'b0100011; mem_ready = 1'b1;
        tick(); tick(); tick();
        mem_ready = 1'b0;
        #1;
        check_eq("store_mem_state", 32'(state), 32'd4);
        check_eq("store_mem_outs", 32'(all_outs), 32'b0_1_1_0_0_0_0_0_00_00_00_0_00_0);
        rst = 1'b1;
        #1;
        check_eq("store_reset_write", 32'(mem_write), 32'd0);
        check_eq("store_reset_outs", 32'(all_outs), 32'd0);
        check_eq("store_reset_state", 32'(state), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check_eq("after_reset_fetch", 32'(state), 32'd1);

        do_illegal(7'b0110001);
        do_illegal(7'b1111111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
